// File: rtl/des_round_ctrl.sv
// Job sequencer for the iterative DES core: accepts a key/direction, runs 16 rounds, then holds the result.
// Optional key-parity checking is enabled by defining DES_KEY_PARITY_EN.
module des_round_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [1:64] in_key,
  output logic [1:64] key,
  output logic        decrypt,
  output logic [3:0]  roundSel,
  output logic        dp_load,
  output logic        dp_round_en,
  output logic        dp_final,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and out_valid/key/decrypt stay frozen until the transfer.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [1:64] key_q, key_d;
  logic        decrypt_q, decrypt_d;
  logic        err_q, err_d;
  logic        parity_ok;
  logic        req;

`ifdef DES_KEY_PARITY_EN
  always_comb begin
    parity_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(^in_key[8*i+1 +: 8])) parity_ok = 1'b0;
    end
  end
`else
  assign parity_ok = 1'b1;
`endif

  // A request seen while reset is high is discarded rather than loaded.
  assign req     = in_valid & in_ready & ~reset;
  assign dp_load = req & parity_ok;
  assign err_d   = req & ~parity_ok;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    key_d     = key_q;
    decrypt_d = decrypt_q;
    case (state_q)
      S_IDLE: begin
        if (dp_load) begin
          key_d     = in_key;
          decrypt_d = in_decrypt;
          round_d   = 4'd0;
          state_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        round_d = round_q + 4'd1;
        if (round_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      round_q   <= 4'd0;
      key_q     <= '0;
      decrypt_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      key_q     <= key_d;
      decrypt_q <= decrypt_d;
      err_q     <= err_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign dp_round_en = (state_q == S_ROUND);
  assign dp_final    = (state_q == S_ROUND) && (round_q == 4'd15);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_ROUND) || (state_q == S_DONE);
  assign roundSel    = round_q;
  assign key         = key_q;
  assign decrypt     = decrypt_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencer for the iterative DES core. It accepts one 64-bit key plus an encrypt/decrypt flag per job over a valid/ready handshake. It then steps the combinational key schedule through rounds 0..15, one round per clock, and drives load, round-enable and final-capture strobes to the L/R datapath registers. Results are presented on an output valid/ready handshake with backpressure. Sits between the host-side job interface and the key-schedule and round-function datapath.

## Interface
- No parameters.
- clk  in  1  single clock; all registers on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  job request
- in_ready  out  1  controller can accept a job; = (state==IDLE)
- in_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled on accept
- in_key  in  [1:64]  DES key incl. parity bits; sampled on accept
- key  out  [1:64]  registered job key, fed to key schedule; held for whole job
- decrypt  out  1  registered job direction, fed to key schedule
- roundSel  out  [3:0]  current round index, always counts 0..15 (key schedule inverts it internally for decrypt)
- dp_load  out  1  combinational; datapath loads IP(data) into L/R at this edge
- dp_round_en  out  1  datapath performs one round at this edge
- dp_final  out  1  datapath captures FP(R16L16) into output register at this edge
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- busy  out  1  high in ROUND and DONE
- err  out  1  one-cycle key-parity error pulse (0 when DES_KEY_PARITY_EN undefined)

## Operation
- States: IDLE, ROUND, DONE. 4-bit round counter drives roundSel.
- IDLE: in_ready=1. Accept = in_valid & in_ready (and parity ok if enabled).
  - On accept: dp_load=1 that cycle; key and decrypt registered; roundSel cleared to 0; next state ROUND.
- ROUND: dp_round_en=1 every cycle. roundSel increments by 1 per cycle.
  - dp_final=1 when roundSel==15; roundSel then wraps to 0; next state DONE.
- DONE: out_valid=1, held stable with key/decrypt until out_valid & out_ready. Next state IDLE.
  - No new job is accepted while in DONE; no input/output overlap.
- dp_round_en, dp_final, out_valid, busy are registered/state-decoded and are never high in IDLE.
- in_valid while busy: ignored, no effect; in_ready=0.
- Reset, any state, including mid-job: immediately returns to IDLE and the job is lost.
  - Reset values: roundSel=0, key=0, decrypt=0, dp_round_en=0, dp_final=0, out_valid=0, busy=0, err=0; in_ready=1 after reset.
  - A handshake coinciding with reset assertion is discarded.

## Timing
- Cycle 0 = accept cycle (dp_load high).
- Cycles 1..16: ROUND, roundSel=0..15, dp_round_en=1; dp_final high in cycle 16.
- Cycle 17: out_valid=1 at earliest.
- With out_ready=1 throughout, IDLE in cycle 18 and the next accept is possible in cycle 18. Throughput is 1 block per 18 cycles.
- out_ready low: DONE holds indefinitely and every output is frozen.
- key/decrypt change only on accept or reset.

## Configuration
- DES_KEY_PARITY_EN defined: each key byte in_key[8i+1:8i+8], i=0..7, must have odd parity.
  - On failure with in_valid in IDLE, the request is consumed (in_ready=1) but no dp_load occurs and the state stays IDLE.
  - err=1 in the following cycle only; key/decrypt are not updated.
- DES_KEY_PARITY_EN undefined: no check, err tied 0, every key accepted.

## Test plan
- Encrypt: key 0x133457799BBCDFF1, in_decrypt=0, out_ready=1 -> dp_load in cycle 0; roundSel 0,1,..,15 in cycles 1..16 with dp_round_en=1; dp_final in cycle 16; out_valid in cycle 17 only; with the real datapath, plaintext 0x0123456789ABCDEF gives 0x85E813540F0AB405.
- Decrypt: same key, in_decrypt=1, ciphertext 0x85E813540F0AB405 -> decrypt=1 held; roundSel still 0..15; result 0x0123456789ABCDEF.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid, key, decrypt, roundSel frozen; in_ready=0; in_valid pulses ignored; IDLE one cycle after out_ready=1.
- Back-to-back: in_valid and out_ready held high -> accepts in cycles 0, 18, 36; no dp_load while busy.
- Reset at roundSel==7 -> all outputs at reset values next sample; a fresh job then runs the full 16 rounds with correct timing.
- Parity (macro defined): key 0x0000000000000000 -> err=1 for one cycle, no dp_load, busy stays 0. Key 0x0101010101010101 -> accepted normally. Macro undefined: the first key is accepted and err stays 0.
